// File: rtl/data_mem_hs.sv
// Big-endian, byte-addressable data memory with valid/ready requests and a registered response.
// Define DMEM_MISALIGN_EN to split misaligned H/HU/W accesses into two word beats (SPLIT state).
module data_mem_hs #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTES = 33'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    logic [2:0] s;
    case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  // Byte enables over the two-word window; bit 7 is byte 0 of the low word.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      3'd1:    m = 8'h80;
      3'd2:    m = 8'hC0;
      default: m = 8'hF0;
    endcase
    return m >> off;
  endfunction

  function automatic logic [63:0] place_store(input logic [31:0] data, input logic [1:0] off,
                                              input logic [2:0] size);
    logic [63:0] w;
    w = {data << {3'd4 - size, 3'b000}, 32'h0};
    return w >> {off, 3'b000};
  endfunction

  function automatic logic [31:0] extract_load(input logic [63:0] win, input logic [1:0] off,
                                               input logic [2:0] size);
    logic [63:0] t;
    t = win << {off, 3'b000};
    return t[63:32] >> {3'd4 - size, 3'b000};
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{v[7]}}, v[7:0]};
      3'b001:  r = {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic          in_split, go_split, acc, err, illegal, range_err, misal;
  logic          sel_we;
  logic [2:0]    sel_f3, req_size, sel_size;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [32:0]   last;
  logic [AW-1:0] widx, widx_hi;
  logic [63:0]   win, st;
  logic [7:0]    be;
  logic [31:0]   ld;

  assign acc = req_valid && req_ready;

  assign req_size  = f3_size(req_f3);
  assign illegal   = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111) ||
                     (req_we && req_f3[2] && !req_f3[1]);
  assign last      = {1'b0, req_addr} + 33'(req_size) - 33'd1;
  assign range_err = (last >= BYTES);
  assign misal     = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_EN
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
  state_t        state, state_nx;
  logic          cap_we;
  logic [2:0]    cap_f3;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_wdata;

  assign err      = illegal || range_err;
  assign go_split = !err && misal;
  assign in_split = (state == SPLIT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !Reset;
        if (req_valid && !Reset && go_split) state_nx = SPLIT;
      end
      SPLIT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (acc) begin
      cap_we    <= req_we;
      cap_f3    <= req_f3;
      cap_addr  <= req_addr[AW+1:0];
      cap_wdata <= req_wdata;
    end
  end

  assign sel_we    = in_split ? cap_we    : req_we;
  assign sel_f3    = in_split ? cap_f3    : req_f3;
  assign sel_addr  = in_split ? cap_addr  : req_addr[AW+1:0];
  assign sel_wdata = in_split ? cap_wdata : req_wdata;
`else
  assign err       = illegal || range_err || misal;
  assign go_split  = 1'b0;
  assign in_split  = 1'b0;
  assign req_ready = !Reset;
  assign sel_we    = req_we;
  assign sel_f3    = req_f3;
  assign sel_addr  = req_addr[AW+1:0];
  assign sel_wdata = req_wdata;
`endif

  // Two-word window: the addressed word and its successor (successor only matters for splits).
  assign sel_size = f3_size(sel_f3);
  assign widx     = sel_addr[AW+1:2];
  assign widx_hi  = (widx == AW'(DEPTH_WORDS - 1)) ? '0 : widx + AW'(1);
  assign win      = {mem[widx], mem[widx_hi]};
  assign be       = lane_mask(sel_addr[1:0], sel_size);
  assign st       = place_store(sel_wdata, sel_addr[1:0], sel_size);
  assign ld       = extend(extract_load(win, sel_addr[1:0], sel_size), sel_f3);

  always_ff @(posedge Clock) begin
    if (acc && req_we && !err) begin
      for (int k = 0; k < 4; k++)
        if (be[7-k]) mem[widx][31-8*k -: 8] <= st[63-8*k -: 8];
    end
    if (in_split && sel_we) begin
      for (int k = 0; k < 4; k++)
        if (be[3-k]) mem[widx_hi][31-8*k -: 8] <= st[31-8*k -: 8];
    end
  end

  // Response stage: one pulse per accepted request, one cycle later for split accesses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (in_split) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_rdata <= sel_we ? 32'h0 : ld;
    end else if (acc && !go_split) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? 32'h0 : ld;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
